// File: rtl/conv_pkg.sv
`default_nettype none
// conv_pkg: shared FSM state type, default generators and legal K/N range.
// Revision 1.0
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TAIL  = 2'd2,
    ST_DRAIN = 2'd3
  } conv_state_t;

  localparam int K_MIN = 3;
  localparam int K_MAX = 9;
  localparam int N_MIN = 2;
  localparam int N_MAX = 4;

  localparam logic [2:0] G1_DEFAULT  = 3'o7;
  localparam logic [2:0] G0_DEFAULT  = 3'o5;
  localparam logic [5:0] GEN_DEFAULT = {G1_DEFAULT, G0_DEFAULT};

endpackage
`default_nettype wire

// File: rtl/conv_tap_xor.sv
`default_nettype none
// conv_tap_xor: parity of each generator's taps over {u, s}, one symbol per generator.
// Revision 1.0
module conv_tap_xor
  import conv_pkg::*;
#(
  parameter int K = 3,
  parameter int N = 2,
  parameter logic [N*K-1:0] GEN = GEN_DEFAULT
) (
  input  logic         u,
  input  logic [K-2:0] s,
  output logic [N-1:0] c
);

  logic [K-1:0] w_reg;
  assign w_reg = {u, s};

  for (genvar j = 0; j < N; j++) begin : g_par
    assign c[j] = ^(GEN[j*K +: K] & w_reg);
  end

endmodule
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// conv_encoder: rate 1/N convolutional encoder, serial symbol output, optional zero tail.
// Revision 1.0
module conv_encoder
  import conv_pkg::*;
#(
  parameter int K = 3,
  parameter int N = 2,
  parameter logic [N*K-1:0] GEN = GEN_DEFAULT,
  parameter bit TAIL_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last,
  output logic busy
);

  localparam int PW = $clog2(N);
  localparam int TW = $clog2(K);
  localparam logic [PW-1:0] c_PH_LAST   = PW'(N - 1);
  localparam logic [TW-1:0] c_TAIL_LAST = TW'(K - 2);

  if (K < K_MIN || K > K_MAX || N < N_MIN || N > N_MAX) begin : g_bad_param
    $error("conv_encoder: K or N outside legal range");
  end

  conv_state_t   r_state;
  conv_state_t   w_state_nxt;
  logic [K-2:0]  r_s;
  logic [N-1:0]  r_buf;
  logic [N-1:0]  w_c;
  logic [PW-1:0] r_phase;
  logic [TW-1:0] r_tail_cnt;
  logic          r_full;
  logic          r_last;
  logic          r_alive;

  logic w_slot_free;
  logic w_acc;
  logic w_tail_load;
  logic w_load;
  logic w_u;
  logic w_final;
  logic w_out_tx;

  // Slot is free when empty, or when the last symbol leaves this cycle (zero-bubble reload).
  assign w_slot_free = !r_full || ((r_phase == c_PH_LAST) && out_ready);
  assign in_ready    = r_alive && w_slot_free &&
                       ((r_state == ST_IDLE) || (r_state == ST_DATA));
  assign w_acc       = in_valid && in_ready;
  assign w_tail_load = (r_state == ST_TAIL) && w_slot_free;
  assign w_load      = w_acc || w_tail_load;
  assign w_u         = w_acc ? in_bit : 1'b0;
  assign w_final     = TAIL_EN ? (w_tail_load && (r_tail_cnt == c_TAIL_LAST))
                               : (w_acc && in_last);
  assign w_out_tx    = r_full && out_ready;

  assign out_valid = r_full;
  assign out_bit   = r_buf[r_phase];
  assign out_last  = r_full && r_last && (r_phase == c_PH_LAST);
  assign busy      = (r_state != ST_IDLE);

  conv_tap_xor #(
    .K   (K),
    .N   (N),
    .GEN (GEN)
  ) u_tap_xor (
    .u (w_u),
    .s (r_s),
    .c (w_c)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DATA: begin
        if (w_acc) begin
          if (in_last) w_state_nxt = TAIL_EN ? ST_TAIL : ST_DRAIN;
          else         w_state_nxt = ST_DATA;
        end
      end
      ST_TAIL:  if (w_final) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_last && out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_s        <= '0;
      r_buf      <= '0;
      r_phase    <= '0;
      r_tail_cnt <= '0;
      r_full     <= 1'b0;
      r_last     <= 1'b0;
      r_alive    <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      r_state <= w_state_nxt;
      if (w_load) begin
        r_buf   <= w_c;
        r_full  <= 1'b1;
        r_phase <= '0;
        r_last  <= w_final;
        // Without a tail the register is flushed explicitly so the next frame starts from zero.
        r_s     <= (w_final && !TAIL_EN) ? '0 : {w_u, r_s[K-2:1]};
      end else if (w_out_tx) begin
        if (r_phase == c_PH_LAST) begin
          r_full  <= 1'b0;
          r_phase <= '0;
        end else begin
          r_phase <= r_phase + 1'b1;
        end
      end
      if (r_state != ST_TAIL)  r_tail_cnt <= '0;
      else if (w_tail_load)    r_tail_cnt <= r_tail_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
